// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, functs, FSM states and datapath select codes
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND   = 3'b000,
    ALU_OR    = 3'b001,
    ALU_ADD   = 3'b010,
    ALU_SLTU  = 3'b011,
    ALU_PASSB = 3'b100,
    ALU_SUB   = 3'b110,
    ALU_SLT   = 3'b111
  } alu_t;

  typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_t;
  typedef enum logic [1:0] {PC_SEQ, PC_BTA, PC_JTA, PC_REG} pc_sel_t;
  typedef enum logic [1:0] {DST_RT, DST_RD, DST_RA} dst_t;
  typedef enum logic [1:0] {WB_ALUOUT, WB_MDR, WB_PC} wsrc_t;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle FSM, instruction decode and datapath enables
module mips_multicycle_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       ready,
  input  logic       zero,
  output logic       memreq,
  output logic       memwrite,
  output logic       addr_sel,
  output logic       ir_en,
  output logic       mdr_en,
  output logic       ab_en,
  output logic       aluout_en,
  output logic       aluout_bta,
  output logic       pc_en,
  output pc_sel_t    pc_sel,
  output logic       alu_srcb_imm,
  output alu_t       alu_ctrl,
  output ext_t       ext_mode,
  output logic       reg_we,
  output dst_t       reg_dst,
  output wsrc_t      reg_src,
  output logic       retire,
  output logic       trap
);

  state_t state, next;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next;
  end

  always_comb begin
    next         = state;
    memreq       = 1'b0;
    memwrite     = 1'b0;
    addr_sel     = 1'b0;
    ir_en        = 1'b0;
    mdr_en       = 1'b0;
    ab_en        = 1'b0;
    aluout_en    = 1'b0;
    aluout_bta   = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = PC_SEQ;
    alu_srcb_imm = 1'b0;
    alu_ctrl     = ALU_ADD;
    ext_mode     = EXT_SIGN;
    reg_we       = 1'b0;
    reg_dst      = DST_RT;
    reg_src      = WB_ALUOUT;
    retire       = 1'b0;
    case (state)
      S_FETCH: begin
        memreq = 1'b1;
        if (ready) begin
          ir_en = 1'b1;
          pc_en = 1'b1;
          next  = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_en      = 1'b1;
        aluout_en  = 1'b1;
        aluout_bta = 1'b1;
        case (op)
          OP_LW, OP_SW:                      next = S_MEMADR;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI: next = S_EXEC;
          OP_BEQ, OP_BNE:                    next = S_BRANCH;
          OP_J, OP_JAL:                      next = S_JUMP;
          OP_RTYPE: begin
            if (funct == FN_JR)     next = S_JUMP;
            else if (funct_ok(funct)) next = S_EXEC;
            else                    next = S_TRAP;
          end
          default:                           next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_srcb_imm = 1'b1;
        aluout_en    = 1'b1;
        next         = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        memreq   = 1'b1;
        addr_sel = 1'b1;
        if (ready) begin
          mdr_en = 1'b1;
          next   = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_we  = 1'b1;
        reg_src = WB_MDR;
        retire  = 1'b1;
        next    = S_FETCH;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        addr_sel = 1'b1;
        if (ready) begin
          retire = 1'b1;
          next   = S_FETCH;
        end
      end
      S_EXEC: begin
        aluout_en = 1'b1;
        if (op == OP_RTYPE) begin
          case (funct)
            FN_SUB, FN_SUBU: alu_ctrl = ALU_SUB;
            FN_AND:          alu_ctrl = ALU_AND;
            FN_OR:           alu_ctrl = ALU_OR;
            FN_SLT:          alu_ctrl = ALU_SLT;
            FN_SLTU:         alu_ctrl = ALU_SLTU;
            default:         alu_ctrl = ALU_ADD;
          endcase
        end else begin
          alu_srcb_imm = 1'b1;
          case (op)
            OP_ORI: begin alu_ctrl = ALU_OR;    ext_mode = EXT_ZERO; end
            OP_LUI: begin alu_ctrl = ALU_PASSB; ext_mode = EXT_LUI;  end
            default:      alu_ctrl = ALU_ADD;
          endcase
        end
        next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = (op == OP_RTYPE) ? DST_RD : DST_RT;
        retire  = 1'b1;
        next    = S_FETCH;
      end
      S_BRANCH: begin
        alu_ctrl = ALU_SUB;
        pc_sel   = PC_BTA;
        pc_en    = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero);
        retire   = 1'b1;
        next     = S_FETCH;
      end
      S_JUMP: begin
        pc_en   = 1'b1;
        pc_sel  = (op == OP_RTYPE) ? PC_REG : PC_JTA;
        reg_we  = (op == OP_JAL);
        reg_dst = DST_RA;
        reg_src = WB_PC;
        retire  = 1'b1;
        next    = S_FETCH;
      end
      default: next = S_TRAP;
    endcase
    // Reset aborts any access in flight and blocks register-file writes.
    if (reset) begin
      memreq   = 1'b0;
      memwrite = 1'b0;
      reg_we   = 1'b0;
    end
  end

  assign trap = (state == S_TRAP);

endmodule

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multicycle MIPS core with unified req/ready memory port
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  output logic        memreq,
  output logic        memwrite,
  output logic [31:0] memaddr,
  output logic [31:0] memwritedata,
  input  logic [31:0] memreaddata,
  input  logic        memready,
  output logic [31:0] pc,
  output logic [31:0] instret,
  output logic        trap
);

  logic [31:0] ir, mdr, a, b, aluout, pc_q, pc_d;
  logic [31:0] rf [0:31];
  logic [31:0] rd1, rd2, ext_imm, srcb, alu_y, bta, jta, wdata;
  logic [4:0]  rs, rt, rd, waddr;
  logic        ready, zero;
  logic        addr_sel, ir_en, mdr_en, ab_en, aluout_en, aluout_bta, pc_en;
  logic        alu_srcb_imm, reg_we, retire;
  pc_sel_t     pc_sel;
  alu_t        alu_ctrl;
  ext_t        ext_mode;
  dst_t        reg_dst;
  wsrc_t       reg_src;

  assign ready = (WAIT_STATES == 0) ? 1'b1 : memready;

  mips_multicycle_ctrl u_ctrl (
    .clk(clk), .reset(reset), .op(ir[31:26]), .funct(ir[5:0]),
    .ready(ready), .zero(zero),
    .memreq(memreq), .memwrite(memwrite), .addr_sel(addr_sel),
    .ir_en(ir_en), .mdr_en(mdr_en), .ab_en(ab_en),
    .aluout_en(aluout_en), .aluout_bta(aluout_bta),
    .pc_en(pc_en), .pc_sel(pc_sel),
    .alu_srcb_imm(alu_srcb_imm), .alu_ctrl(alu_ctrl), .ext_mode(ext_mode),
    .reg_we(reg_we), .reg_dst(reg_dst), .reg_src(reg_src),
    .retire(retire), .trap(trap)
  );

  assign rs = ir[25:21];
  assign rt = ir[20:16];
  assign rd = ir[15:11];

  assign rd1 = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rd2 = (rt == 5'd0) ? 32'd0 : rf[rt];

  always_comb begin
    case (ext_mode)
      EXT_ZERO: ext_imm = {16'd0, ir[15:0]};
      EXT_LUI:  ext_imm = {ir[15:0], 16'd0};
      default:  ext_imm = {{16{ir[15]}}, ir[15:0]};
    endcase
  end

  assign srcb = alu_srcb_imm ? ext_imm : b;

  always_comb begin
    case (alu_ctrl)
      ALU_AND:   alu_y = a & srcb;
      ALU_OR:    alu_y = a | srcb;
      ALU_ADD:   alu_y = a + srcb;
      ALU_SUB:   alu_y = a - srcb;
      ALU_SLT:   alu_y = {31'd0, $signed(a) < $signed(srcb)};
      ALU_SLTU:  alu_y = {31'd0, a < srcb};
      ALU_PASSB: alu_y = srcb;
      default:   alu_y = 32'd0;
    endcase
  end

  assign zero = (alu_y == 32'd0);
  // pc_q already holds old pc + 4 by DECODE, so this is the architectural branch target.
  assign bta  = pc_q + (ext_imm << 2);
  assign jta  = {pc_q[31:28], ir[25:0], 2'b00};

  always_comb begin
    case (pc_sel)
      PC_BTA:  pc_d = aluout;
      PC_JTA:  pc_d = jta;
      PC_REG:  pc_d = a;
      default: pc_d = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    case (reg_dst)
      DST_RD:  waddr = rd;
      DST_RA:  waddr = 5'd31;
      default: waddr = rt;
    endcase
    case (reg_src)
      WB_MDR:  wdata = mdr;
      WB_PC:   wdata = pc_q;
      default: wdata = aluout;
    endcase
  end

  assign memaddr      = addr_sel ? aluout : pc_q;
  assign memwritedata = b;

  always_ff @(posedge clk) begin
    if (reg_we && (waddr != 5'd0)) rf[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (ir_en)     ir     <= memreaddata;
    if (mdr_en)    mdr    <= memreaddata;
    if (ab_en) begin
      a <= rd1;
      b <= rd2;
    end
    if (aluout_en) aluout <= aluout_bta ? bta : alu_y;
  end

  // pc (output) tracks the instruction in flight; pc_q runs ahead once fetch completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      pc      <= RESET_PC;
      instret <= 32'd0;
    end else begin
      if (pc_en) pc_q <= pc_d;
      if (retire) begin
        instret <= instret + 32'd1;
        pc      <= pc_en ? pc_d : pc_q;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - directed self-checking bench for mips_multicycle
module tb_mips_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        memreq, memwrite, memready, trap;
  logic [31:0] memaddr, memwritedata, memreaddata, pc, instret;

  int total = 0;
  int bad = 0;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];
  logic [255:0] dval;
  int wait_cnt = 0;
  int data_delay = 0;
  int wr_count = 0;

  mips_multicycle #(.RESET_PC(32'h0), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .memreq(memreq), .memwrite(memwrite),
    .memaddr(memaddr), .memwritedata(memwritedata), .memreaddata(memreaddata),
    .memready(memready), .pc(pc), .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  // Memory: program words in imem, DUT stores overlay dmem; only address 0x10 is slow.
  wire [7:0] widx = memaddr[9:2];
  assign memreaddata = dval[widx] ? dmem[widx] : imem[widx];
  assign memready    = memreq && (wait_cnt >= ((memaddr == 32'h10) ? data_delay : 0));

  always @(posedge clk) begin
    if (reset) begin
      dval     <= '0;
      wait_cnt <= 0;
    end else if (memreq && !memready) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      if (memreq && memwrite) begin
        dmem[widx] <= memwritedata;
        dval[widx] <= 1'b1;
        wr_count   <= wr_count + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until(input logic [31:0] n, input int maxc, output int cyc);
    cyc = 0;
    while (instret !== n && cyc < maxc) begin
      tick();
      cyc++;
    end
  endtask

  task automatic begin_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0000;
  endtask

  task automatic end_reset();
    repeat (2) tick();
    check("rst_memreq", {31'd0, memreq}, 32'd0);
    check("rst_memwrite", {31'd0, memwrite}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_pc", pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_req", {31'd0, memreq}, 32'd1);
    check("first_addr", memaddr, 32'h0);
  endtask

  int cyc, wr, rdc, wrsave;

  initial begin
    // Reset and ALU program: addi, addi, sltu, slt, then branch-to-self
    begin_reset();
    data_delay = 0;
    imem[0] = 32'h2001_0005;
    imem[1] = 32'h2002_FFFF;
    imem[2] = 32'h0022_182B;
    imem[3] = 32'h0022_202A;
    imem[4] = 32'h1000_FFFF;
    end_reset();
    run_until(32'd4, 40, cyc);
    check("alu_cycles", cyc, 32'd16);
    check("alu_instret", instret, 32'd4);
    check("r1", dut.rf[1], 32'd5);
    check("r2", dut.rf[2], 32'hFFFF_FFFF);
    check("sltu_r3", dut.rf[3], 32'd1);
    check("slt_r4", dut.rf[4], 32'd0);
    check("alu_pc", pc, 32'h10);
    run_until(32'd7, 30, cyc);
    check("loop_cycles", cyc, 32'd9);
    check("loop_pc", pc, 32'h10);

    // Store then load with three wait cycles on each data access
    begin_reset();
    data_delay = 3;
    imem[0] = 32'h2001_0005;
    imem[1] = 32'hAC01_0010;
    imem[2] = 32'h8C05_0010;
    imem[3] = 32'h1000_FFFF;
    end_reset();
    run_until(32'd1, 20, cyc);
    check("t3_addi_cycles", cyc, 32'd4);
    cyc = 0;
    wr = 0;
    while (instret !== 32'd2 && cyc < 40) begin
      tick();
      cyc++;
      if (memreq && memwrite) begin
        wr++;
        check("sw_addr", memaddr, 32'h10);
        check("sw_data", memwritedata, 32'd5);
      end
    end
    check("sw_cycles", cyc, 32'd7);
    check("sw_req_cycles", wr, 32'd4);
    cyc = 0;
    rdc = 0;
    while (instret !== 32'd3 && cyc < 40) begin
      tick();
      cyc++;
      if (memreq && !memwrite && memaddr == 32'h10) rdc++;
    end
    check("lw_cycles", cyc, 32'd8);
    check("lw_req_cycles", rdc, 32'd4);
    check("lw_r5", dut.rf[5], 32'd5);
    check("mem_10", dmem[4], 32'd5);

    // $0 write discard, jal / jr / bne not taken
    begin_reset();
    data_delay = 0;
    imem[0]  = 32'h2000_0007;
    imem[1]  = 32'h2006_0001;
    imem[2]  = 32'h0C00_0010;
    imem[3]  = 32'h1400_0005;
    imem[4]  = 32'h1000_FFFF;
    imem[16] = 32'h03E0_0008;
    end_reset();
    run_until(32'd2, 20, cyc);
    check("zero_reg_cycles", cyc, 32'd8);
    check("r6_from_r0", dut.rf[6], 32'd1);
    run_until(32'd3, 10, cyc);
    check("jal_cycles", cyc, 32'd3);
    check("jal_link", dut.rf[31], 32'hC);
    check("jal_pc", pc, 32'h40);
    check("jal_fetch", memaddr, 32'h40);
    run_until(32'd4, 10, cyc);
    check("jr_cycles", cyc, 32'd3);
    check("jr_pc", pc, 32'hC);
    check("jr_fetch", memaddr, 32'hC);
    run_until(32'd5, 10, cyc);
    check("bne_cycles", cyc, 32'd3);
    check("bne_pc", pc, 32'h10);
    check("bne_fetch", memaddr, 32'h10);

    // Illegal opcode traps after DECODE and stays there
    begin_reset();
    imem[0] = 32'h2001_0005;
    imem[1] = 32'hFC00_0000;
    end_reset();
    run_until(32'd1, 20, cyc);
    tick();
    check("pre_trap", {31'd0, trap}, 32'd0);
    tick();
    check("trap_set", {31'd0, trap}, 32'd1);
    check("trap_memreq", {31'd0, memreq}, 32'd0);
    repeat (5) tick();
    check("trap_sticky", {31'd0, trap}, 32'd1);
    check("trap_idle", {31'd0, memreq}, 32'd0);
    check("trap_instret", instret, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("trap_cleared", {31'd0, trap}, 32'd0);

    // Illegal funct inside R-type
    begin_reset();
    imem[0] = 32'h0000_003F;
    end_reset();
    tick();
    tick();
    check("funct_trap", {31'd0, trap}, 32'd1);
    check("funct_instret", instret, 32'd0);

    // Reset during a store wait state aborts the write
    begin_reset();
    data_delay = 10;
    imem[0] = 32'h2001_0005;
    imem[1] = 32'hAC01_0010;
    imem[2] = 32'h1000_FFFF;
    end_reset();
    wrsave = wr_count;
    run_until(32'd1, 20, cyc);
    repeat (3) tick();
    check("abort_pre_wr", {31'd0, memwrite}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_memwrite", {31'd0, memwrite}, 32'd0);
    check("abort_memreq", {31'd0, memreq}, 32'd0);
    tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_fetch_req", {31'd0, memreq}, 32'd1);
    check("abort_fetch_addr", memaddr, 32'h0);
    check("abort_instret", instret, 32'd0);
    check("abort_no_write", wr_count, wrsave);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
